// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing the cons-cell memory port between core (r0) and allocator/GC (r1)
// Optional feature macro: MEM_ARB_TIMEOUT_EN (WAIT-state watchdog, adds TIMEOUT_CYCLES parameter and rN_err reporting)
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wr_header,
  input  logic [DATA_W-1:0] r0_wr_car,
  input  logic [DATA_W-1:0] r0_wr_cdr,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wr_header,
  input  logic [DATA_W-1:0] r1_wr_car,
  input  logic [DATA_W-1:0] r1_wr_cdr,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] rd_header,
  output logic [DATA_W-1:0] rd_car,
  output logic [DATA_W-1:0] rd_cdr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_header,
  output logic [DATA_W-1:0] mem_wr_car,
  output logic [DATA_W-1:0] mem_wr_cdr,
  input  logic [DATA_W-1:0] mem_rd_header,
  input  logic [DATA_W-1:0] mem_rd_car,
  input  logic [DATA_W-1:0] mem_rd_cdr,
  input  logic              mem_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_grant;  // requester granted most recently (1 = r1)
  logic   r_winner;      // requester owning the current access (1 = r1)
  logic   r_we;
  logic   w_any_req;
  logic   w_pick;
  logic   w_timeout;

  assign w_any_req = r0_req | r1_req;
  // On a tie the requester that did not go last wins; otherwise whoever asks.
  assign w_pick    = (r0_req && r1_req) ? ~r_last_grant : r1_req;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // The count tracks completed WAIT cycles; the final one ends the access.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and error flag; a mem_done in the last cycle still wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (mem_done) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign r0_err = (r_state == S_RESP) && !r_winner && r_err;
  assign r1_err = (r_state == S_RESP) &&  r_winner && r_err;
`else
  assign w_timeout = 1'b0;
  assign r0_err    = 1'b0;
  assign r1_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe/handshake decode.
  always_comb begin
    w_next    = r_state;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    r0_done   = 1'b0;
    r1_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_rd_en = !r_we;
        mem_wr_en = r_we;
        r0_gnt    = !r_winner;
        r1_gnt    = r_winner;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        r0_done = !r_winner;
        r1_done = r_winner;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Access latch, grant history and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant  <= 1'b1;
      r_winner      <= 1'b0;
      r_we          <= 1'b0;
      mem_addr      <= '0;
      mem_wr_header <= '0;
      mem_wr_car    <= '0;
      mem_wr_cdr    <= '0;
      rd_header     <= '0;
      rd_car        <= '0;
      rd_cdr        <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_winner      <= w_pick;
        r_we          <= w_pick ? r1_we        : r0_we;
        mem_addr      <= w_pick ? r1_addr      : r0_addr;
        mem_wr_header <= w_pick ? r1_wr_header : r0_wr_header;
        mem_wr_car    <= w_pick ? r1_wr_car    : r0_wr_car;
        mem_wr_cdr    <= w_pick ? r1_wr_cdr    : r0_wr_cdr;
      end
      if (r_state == S_ISSUE) begin
        r_last_grant <= r_winner;
      end
      if (r_state == S_WAIT && mem_done && !r_we) begin
        rd_header <= mem_rd_header;
        rd_car    <= mem_rd_car;
        rd_cdr    <= mem_rd_cdr;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a latency-programmable memory model
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [15:0] r0_addr = '0, r0_wr_header = '0, r0_wr_car = '0, r0_wr_cdr = '0;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [15:0] r1_addr = '0, r1_wr_header = '0, r1_wr_car = '0, r1_wr_cdr = '0;
  logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
  logic [15:0] rd_header, rd_car, rd_cdr;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_addr, mem_wr_header, mem_wr_car, mem_wr_cdr;
  logic [15:0] mem_rd_header = '0, mem_rd_car = '0, mem_rd_cdr = '0;
  logic        m_done = 1'b0, stray_done = 1'b0;
  logic        mem_done;
  assign mem_done = m_done | stray_done;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8)) dut (
`else
  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
`endif
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wr_header(r0_wr_header), .r0_wr_car(r0_wr_car), .r0_wr_cdr(r0_wr_cdr),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wr_header(r1_wr_header), .r1_wr_car(r1_wr_car), .r1_wr_cdr(r1_wr_cdr),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err),
    .rd_header(rd_header), .rd_car(rd_car), .rd_cdr(rd_cdr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_header(mem_wr_header), .mem_wr_car(mem_wr_car), .mem_wr_cdr(mem_wr_cdr),
    .mem_rd_header(mem_rd_header), .mem_rd_car(mem_rd_car), .mem_rd_cdr(mem_rd_cdr),
    .mem_done(mem_done)
  );

  logic [119:0] all_out;
  assign all_out = {r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err, rd_header, rd_car, rd_cdr,
                    mem_rd_en, mem_wr_en, mem_addr, mem_wr_header, mem_wr_car, mem_wr_cdr};

  typedef struct {
    bit          who;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wc;
    logic [15:0] ecar;
    logic [15:0] ehdr;
    bit          err;
  } exp_t;

  typedef struct {
    bit          we0, we1;
    logic [15:0] a0, a1, wc0, wc1;
    int          n0, n1, lat;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[7];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, gnt_cyc = 0, done_cyc = 0;
  int          lat = 1, mcnt = 0;
  bit          busy = 0, exp_last = 1;
  logic [15:0] cur_addr = '0, exp_rd = '0, exp_hdr = '0;
  logic [15:0] img_h[256], img_c[256], img_d[256], gold_h[256], gold_c[256];
  bit          m_we = 0;
  logic [7:0]  m_addr = '0;
  logic [15:0] m_wh = '0, m_wc = '0, m_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample DUT on the falling edge, score it, then advance the memory model.
  task automatic tick();
    exp_t e;
    bit   md_was;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      busy = 0; mcnt = 0; m_done = 1'b0;
      return;
    end
    md_was = mem_done;
    if (r0_gnt || r1_gnt) begin
      gnt_cyc = cyc;
      chk("gnt_onehot", 32'(r0_gnt & r1_gnt), 0);
      if (q.size() == 0) chk("gnt_expected", 1, 0);
      else begin
        e = q[0];
        chk("gnt_who", 32'(r1_gnt), 32'(e.who));
        chk("strobe_rd", 32'(mem_rd_en), 32'(!e.we));
        chk("strobe_wr", 32'(mem_wr_en), 32'(e.we));
        chk("issue_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) chk("issue_wcar", 32'(mem_wr_car), 32'(e.wc));
        busy = 1; cur_addr = e.addr;
      end
    end else if (r0_done || r1_done) begin
      done_cyc = cyc; busy = 0;
      chk("done_onehot", 32'(r0_done & r1_done), 0);
      if (q.size() == 0) chk("done_expected", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_who", 32'(r1_done), 32'(e.who));
        chk("done_err", 32'(r1_done ? r1_err : r0_err), 32'(e.err));
        chk("rd_car", 32'(rd_car), 32'(e.ecar));
        chk("rd_header", 32'(rd_header), 32'(e.ehdr));
        if (!e.err) chk("done_after_mem_done", 32'(md_was), 1);
      end
    end else if (busy) begin
      chk("wait_addr_stable", 32'(mem_addr), 32'(cur_addr));
      chk("wait_no_strobe", 32'(mem_rd_en | mem_wr_en), 0);
    end
    m_done = 1'b0;
    if (mem_rd_en || mem_wr_en) begin
      m_we = mem_wr_en; m_addr = mem_addr[7:0];
      m_wh = mem_wr_header; m_wc = mem_wr_car; m_wd = mem_wr_cdr;
      mcnt = lat;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        m_done = 1'b1;
        if (m_we) begin
          img_h[m_addr] = m_wh; img_c[m_addr] = m_wc; img_d[m_addr] = m_wd;
        end else begin
          mem_rd_header = img_h[m_addr]; mem_rd_car = img_c[m_addr]; mem_rd_cdr = img_d[m_addr];
        end
      end
    end
  endtask

  task automatic push_exp(input bit who, input bit we, input logic [15:0] addr,
                          input logic [15:0] wc, input bit err);
    exp_t e;
    e.who = who; e.we = we; e.addr = addr; e.wc = wc; e.err = err;
    if (we) begin
      gold_c[addr[7:0]] = wc;
      gold_h[addr[7:0]] = 16'h00FF;
    end else if (!err) begin
      exp_rd  = gold_c[addr[7:0]];
      exp_hdr = gold_h[addr[7:0]];
    end
    e.ecar = exp_rd; e.ehdr = exp_hdr;
    q.push_back(e);
    exp_last = who;
  endtask

  task automatic run_vec(input vec_t v);
    int  c0, c1, rem0, rem1;
    bit  w;
    r0_we = v.we0; r0_addr = v.a0; r0_wr_car = v.wc0; r0_wr_header = 16'h00FF; r0_wr_cdr = ~v.wc0;
    r1_we = v.we1; r1_addr = v.a1; r1_wr_car = v.wc1; r1_wr_header = 16'h00FF; r1_wr_cdr = ~v.wc1;
    lat = v.lat;
    c0 = 0; c1 = 0;
    while (c0 < v.n0 || c1 < v.n1) begin
      if (c0 < v.n0 && c1 < v.n1) w = !exp_last;
      else                        w = (c1 < v.n1);
      if (w) begin push_exp(1'b1, v.we1, v.a1, v.wc1, 1'b0); c1++; end
      else   begin push_exp(1'b0, v.we0, v.a0, v.wc0, 1'b0); c0++; end
    end
    r0_req = (v.n0 > 0); r1_req = (v.n1 > 0);
    rem0 = v.n0; rem1 = v.n1;
    tick();
    chk("gnt_next_cycle", 32'(r0_gnt | r1_gnt), 1);
    for (int k = 0; k < 400 && (rem0 > 0 || rem1 > 0); k++) begin
      tick();
      if (r0_done && rem0 > 0) begin rem0--; if (rem0 == 0) r0_req = 1'b0; end
      if (r1_done && rem1 > 0) begin rem1--; if (rem1 == 0) r1_req = 1'b0; end
    end
    chk("vector_completed", 32'(rem0 + rem1), 0);
    r0_req = 1'b0; r1_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      img_c[i] = {8'hC0, 8'(i)}; img_h[i] = {8'h00, 8'(i)}; img_d[i] = ~{8'hC0, 8'(i)};
      gold_c[i] = img_c[i]; gold_h[i] = img_h[i];
    end
    img_h[16] = 16'h0001; img_c[16] = 16'h002A; gold_h[16] = 16'h0001; gold_c[16] = 16'h002A;

    //            we0 we1 a0        a1        wc0       wc1       n0 n1 lat
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0011, 16'h0000, 16'h0000, 1, 1, 1};
    vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1, 0, 2};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 16'h0020, 16'h0000, 16'h1234, 0, 1, 3};
    vecs[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1};
    vecs[4] = '{1'b0, 1'b0, 16'h0007, 16'h0008, 16'h0000, 16'h0000, 2, 2, 2};
    vecs[5] = '{1'b1, 1'b0, 16'h0030, 16'h0030, 16'hBEEF, 16'h0000, 1, 1, 2};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0030, 16'h0000, 16'h0000, 0, 1, 1};

    rst = 1'b0;
    tick(); tick();
    chk("reset_outputs_zero", 32'(|all_out), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stray completion pulses while idle must produce nothing.
    stray_done = 1'b1;
    tick();
    chk("stray_quiet_a", 32'({r0_gnt, r1_gnt, r0_done, r1_done, mem_rd_en, mem_wr_en}), 0);
    stray_done = 1'b0;
    tick();
    chk("stray_quiet_b", 32'({r0_gnt, r1_gnt, r0_done, r1_done, mem_rd_en, mem_wr_en}), 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: the watchdog ends the access with an error.
    lat = 0; r0_we = 1'b0; r0_addr = 16'h0050;
    push_exp(1'b0, 1'b0, 16'h0050, 16'h0000, 1'b1);
    r0_req = 1'b1;
    for (int k = 0; k < 40 && !r0_done; k++) tick();
    chk("timeout_done_seen", 32'(r0_done), 1);
    chk("timeout_latency", 32'(done_cyc - gnt_cyc), 9);
    r0_req = 1'b0;
    tick(); tick();
`endif

    // Reset while an access hangs in WAIT, then a fresh request completes.
    lat = 0; r1_we = 1'b0; r1_addr = 16'h0040;
    push_exp(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    r1_req = 1'b1;
    for (int k = 0; k < 5 && !r1_gnt; k++) tick();
    chk("hang_gnt_seen", 32'(r1_gnt), 1);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_mid_wait_zero", 32'(|all_out), 0);
    tick(); tick();
    exp_last = 1'b1;
    lat = 2;
    rst = 1'b1;
    for (int k = 0; k < 50 && !r1_done; k++) tick();
    chk("post_reset_done", 32'(r1_done), 1);
    r1_req = 1'b0;
    tick(); tick();

    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
